// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and data load/store (D).
// Define ARB_RR_EN for round-robin tie breaking; the default is fixed D priority.
module mem_port_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          sel,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t        state;
    state_t        state_nxt;
    logic          grant_d;

    logic          mem_req_nxt;
    logic          mem_we_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt;
    logic          sel_nxt;
    logic          busy_nxt;
    logic          i_ack_nxt;
    logic          d_ack_nxt;
    logic [DW-1:0] i_rdata_nxt;
    logic [DW-1:0] d_rdata_nxt;

`ifdef ARB_RR_EN
    logic          last_owner;
    logic          last_owner_nxt;

    // On a tie the side that did not own the previous grant wins.
    always_comb begin
        grant_d = d_req & (~i_req | (last_owner == OWNER_I));
    end
`else
    // Fixed priority: any data request beats a fetch.
    always_comb begin
        grant_d = d_req;
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        sel_nxt       = sel;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
`ifdef ARB_RR_EN
        last_owner_nxt = last_owner;
`endif

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nxt     = BUSY;
                    mem_req_nxt   = 1'b1;
                    sel_nxt       = grant_d ? OWNER_D : OWNER_I;
                    mem_we_nxt    = grant_d & d_we;
                    mem_addr_nxt  = grant_d ? d_addr : i_addr;
                    mem_wdata_nxt = grant_d ? d_wdata : DW'(0);
`ifdef ARB_RR_EN
                    last_owner_nxt = grant_d ? OWNER_D : OWNER_I;
`endif
                end
            end
            BUSY: begin
                // Latched request is held; requester inputs are not looked at here.
                if (mem_ack) begin
                    state_nxt   = RESP;
                    mem_req_nxt = 1'b0;
                    if (sel == OWNER_D) begin
                        d_ack_nxt   = 1'b1;
                        d_rdata_nxt = mem_rdata;
                    end else begin
                        i_ack_nxt   = 1'b1;
                        i_rdata_nxt = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            sel       <= OWNER_I;
            busy      <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            sel       <= sel_nxt;
            busy      <= busy_nxt;
            i_ack     <= i_ack_nxt;
            d_ack     <= d_ack_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
        end
    end

`ifdef ARB_RR_EN
    // Reset to D so that I takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= OWNER_D;
        end else begin
            last_owner <= last_owner_nxt;
        end
    end
`endif

endmodule
